// File: rtl/csr_intc_pkg.sv
// rtl/csr_intc_pkg.sv - CSR addresses, mstatus bit indices, causes and intc state encodings
package csr_intc_pkg;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;

   localparam logic [31:0] TIMER_IRQ_CAUSE = 32'h8000_0007;

   typedef enum logic [2:0] {
      INTC_IDLE         = 3'd0,
      INTC_W_MEPC       = 3'd1,
      INTC_W_MSTATUS    = 3'd2,
      INTC_W_MCAUSE     = 3'd3,
      INTC_ASSERT       = 3'd4,
      INTC_MRET_MSTATUS = 3'd5,
      INTC_MRET_ASSERT  = 3'd6
   } intc_state_e;

   // Trap entry: MPIE <= MIE, MIE <= 0
   function automatic logic [31:0] trap_mstatus(input logic [31:0] ms);
      logic [31:0] r;
      r               = ms;
      r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
      r[MSTATUS_MIE]  = 1'b0;
      return r;
   endfunction

   // Return: MIE <= MPIE, MPIE <= 1
   function automatic logic [31:0] mret_mstatus(input logic [31:0] ms);
      logic [31:0] r;
      r               = ms;
      r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
      r[MSTATUS_MPIE] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/csr_intc.sv
// rtl/csr_intc.sv - trap/interrupt sequencer driving the CSR file intc write port
// Optional timer interrupt input enabled by CSR_INTC_TIMER_IRQ_EN.
module csr_intc
   import csr_intc_pkg::*;
#(
   parameter logic [31:0] EXT_IRQ_CAUSE = 32'h8000_000B,
   parameter logic [31:0] ECALL_CAUSE   = 32'h0000_000B,
   parameter logic [31:0] EBREAK_CAUSE  = 32'h0000_0003
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        irq_i,
`ifdef CSR_INTC_TIMER_IRQ_EN
   input  logic        timer_irq_i,
`endif
   input  logic        ecall_i,
   input  logic        ebreak_i,
   input  logic        mret_i,
   input  logic [31:0] inst_addr_i,
   input  logic        jump_flag_i,
   input  logic [31:0] jump_addr_i,
   input  logic        csr_ex_we_i,
   input  logic [31:0] csr_mtvec_i,
   input  logic [31:0] csr_mepc_i,
   input  logic [31:0] csr_mstatus_i,
   output logic [11:0] csr_intc_addr_o,
   output logic [31:0] csr_intc_data_o,
   output logic        csr_intc_we_o,
   output logic        hold_flag_o,
   output logic        int_assert_o,
   output logic [31:0] int_addr_o
);

   intc_state_e state_q, state_d;
   logic [31:0] cause_q, epc_q;
   logic        take_trap;
   logic [31:0] trap_cause, trap_epc, irq_epc;
   logic        mie;

   assign mie     = csr_mstatus_i[MSTATUS_MIE];
   // An interrupt returns to the EX redirect target if one is in flight
   assign irq_epc = jump_flag_i ? jump_addr_i : inst_addr_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= INTC_IDLE;
         cause_q <= '0;
         epc_q   <= '0;
      end else begin
         state_q <= state_d;
         if (take_trap) begin
            cause_q <= trap_cause;
            epc_q   <= trap_epc;
         end
      end
   end

   always_comb begin
      state_d         = state_q;
      take_trap       = 1'b0;
      trap_cause      = '0;
      trap_epc        = '0;
      csr_intc_addr_o = '0;
      csr_intc_data_o = '0;
      csr_intc_we_o   = 1'b0;
      hold_flag_o     = 1'b0;
      int_assert_o    = 1'b0;
      int_addr_o      = '0;
      case (state_q)
         INTC_IDLE: begin
            if (ecall_i) begin
               take_trap  = 1'b1;
               trap_cause = ECALL_CAUSE;
               trap_epc   = inst_addr_i;
            end else if (ebreak_i) begin
               take_trap  = 1'b1;
               trap_cause = EBREAK_CAUSE;
               trap_epc   = inst_addr_i;
            end else if (mret_i) begin
               state_d = INTC_MRET_MSTATUS;
            end else if (irq_i && mie) begin
               take_trap  = 1'b1;
               trap_cause = EXT_IRQ_CAUSE;
               trap_epc   = irq_epc;
            end
`ifdef CSR_INTC_TIMER_IRQ_EN
            else if (timer_irq_i && mie) begin
               take_trap  = 1'b1;
               trap_cause = TIMER_IRQ_CAUSE;
               trap_epc   = irq_epc;
            end
`endif
            if (take_trap) state_d = INTC_W_MEPC;
         end
         // Write states hold off while EX owns the CSR write port
         INTC_W_MEPC: begin
            hold_flag_o     = 1'b1;
            csr_intc_addr_o = CSR_MEPC;
            csr_intc_data_o = epc_q;
            csr_intc_we_o   = !csr_ex_we_i;
            if (!csr_ex_we_i) state_d = INTC_W_MSTATUS;
         end
         INTC_W_MSTATUS: begin
            hold_flag_o     = 1'b1;
            csr_intc_addr_o = CSR_MSTATUS;
            csr_intc_data_o = trap_mstatus(csr_mstatus_i);
            csr_intc_we_o   = !csr_ex_we_i;
            if (!csr_ex_we_i) state_d = INTC_W_MCAUSE;
         end
         INTC_W_MCAUSE: begin
            hold_flag_o     = 1'b1;
            csr_intc_addr_o = CSR_MCAUSE;
            csr_intc_data_o = cause_q;
            csr_intc_we_o   = !csr_ex_we_i;
            if (!csr_ex_we_i) state_d = INTC_ASSERT;
         end
         INTC_ASSERT: begin
            hold_flag_o  = 1'b1;
            int_assert_o = 1'b1;
            int_addr_o   = csr_mtvec_i;
            state_d      = INTC_IDLE;
         end
         INTC_MRET_MSTATUS: begin
            hold_flag_o     = 1'b1;
            csr_intc_addr_o = CSR_MSTATUS;
            csr_intc_data_o = mret_mstatus(csr_mstatus_i);
            csr_intc_we_o   = !csr_ex_we_i;
            if (!csr_ex_we_i) state_d = INTC_MRET_ASSERT;
         end
         INTC_MRET_ASSERT: begin
            hold_flag_o  = 1'b1;
            int_assert_o = 1'b1;
            int_addr_o   = csr_mepc_i;
            state_d      = INTC_IDLE;
         end
         default: state_d = INTC_IDLE;
      endcase
   end

endmodule

// File: tb/tb_csr_intc.sv
// tb/tb_csr_intc.sv - directed self-checking bench for csr_intc
module tb_csr_intc;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        irq_i, ecall_i, ebreak_i, mret_i, jump_flag_i, csr_ex_we_i;
   logic [31:0] inst_addr_i, jump_addr_i, csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
   logic [11:0] csr_intc_addr_o;
   logic [31:0] csr_intc_data_o, int_addr_o;
   logic        csr_intc_we_o, hold_flag_o, int_assert_o;
`ifdef CSR_INTC_TIMER_IRQ_EN
   logic        timer_irq_i = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   csr_intc dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .irq_i           (irq_i),
`ifdef CSR_INTC_TIMER_IRQ_EN
      .timer_irq_i     (timer_irq_i),
`endif
      .ecall_i         (ecall_i),
      .ebreak_i        (ebreak_i),
      .mret_i          (mret_i),
      .inst_addr_i     (inst_addr_i),
      .jump_flag_i     (jump_flag_i),
      .jump_addr_i     (jump_addr_i),
      .csr_ex_we_i     (csr_ex_we_i),
      .csr_mtvec_i     (csr_mtvec_i),
      .csr_mepc_i      (csr_mepc_i),
      .csr_mstatus_i   (csr_mstatus_i),
      .csr_intc_addr_o (csr_intc_addr_o),
      .csr_intc_data_o (csr_intc_data_o),
      .csr_intc_we_o   (csr_intc_we_o),
      .hold_flag_o     (hold_flag_o),
      .int_assert_o    (int_assert_o),
      .int_addr_o      (int_addr_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_we"},   {31'd0, csr_intc_we_o}, 32'd0);
      chk({tag, "_addr"}, {20'd0, csr_intc_addr_o}, 32'd0);
      chk({tag, "_data"}, csr_intc_data_o, 32'd0);
      chk({tag, "_hold"}, {31'd0, hold_flag_o}, 32'd0);
      chk({tag, "_ia"},   {31'd0, int_assert_o}, 32'd0);
      chk({tag, "_iaddr"}, int_addr_o, 32'd0);
   endtask

   task automatic chk_wr(input string tag, input logic [11:0] a, input logic [31:0] d);
      chk({tag, "_we"},   {31'd0, csr_intc_we_o}, 32'd1);
      chk({tag, "_addr"}, {20'd0, csr_intc_addr_o}, {20'd0, a});
      chk({tag, "_data"}, csr_intc_data_o, d);
      chk({tag, "_hold"}, {31'd0, hold_flag_o}, 32'd1);
      chk({tag, "_ia"},   {31'd0, int_assert_o}, 32'd0);
   endtask

   task automatic chk_redir(input string tag, input logic [31:0] a);
      chk({tag, "_ia"},   {31'd0, int_assert_o}, 32'd1);
      chk({tag, "_iaddr"}, int_addr_o, a);
      chk({tag, "_we"},   {31'd0, csr_intc_we_o}, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; irq_i = 1'b0; ecall_i = 1'b0; ebreak_i = 1'b0; mret_i = 1'b0;
      jump_flag_i = 1'b0; csr_ex_we_i = 1'b0;
      inst_addr_i = 32'h0; jump_addr_i = 32'h0; csr_mtvec_i = 32'h200;
      csr_mepc_i = 32'h0; csr_mstatus_i = 32'h8;

      // Reset state
      repeat (2) @(negedge clk);
      chk_idle("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // ecall: mepc=0x100, mstatus=0x80, mcause=0xB, redirect to 0x200 on cycle 4
      inst_addr_i = 32'h100; ecall_i = 1'b1;
      chk_idle("ecall_c0");
      @(negedge clk); ecall_i = 1'b0;
      chk_wr("ecall_mepc", 12'h341, 32'h100);
      @(negedge clk);
      chk_wr("ecall_mstatus", 12'h300, 32'h80);
      @(negedge clk);
      chk_wr("ecall_mcause", 12'h342, 32'hB);
      @(negedge clk);
      chk_redir("ecall_redir", 32'h200);
      chk("ecall_redir_hold", {31'd0, hold_flag_o}, 32'd1);
      @(negedge clk);
      chk_idle("ecall_done");

      // irq during an EX jump: epc from jump_addr
      inst_addr_i = 32'h500; irq_i = 1'b1; jump_flag_i = 1'b1; jump_addr_i = 32'h340;
      @(negedge clk); irq_i = 1'b0; jump_flag_i = 1'b0;
      chk_wr("irq_mepc", 12'h341, 32'h340);
      @(negedge clk);
      chk_wr("irq_mstatus", 12'h300, 32'h80);
      @(negedge clk);
      chk_wr("irq_mcause", 12'h342, 32'h8000000B);
      @(negedge clk);
      chk_redir("irq_redir", 32'h200);
      @(negedge clk);
      chk_idle("irq_done");

      // irq masked by MIE=0 for 10 cycles
      csr_mstatus_i = 32'h80; irq_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("masked_we", {31'd0, csr_intc_we_o}, 32'd0);
         chk("masked_hold", {31'd0, hold_flag_o}, 32'd0);
      end
      // MIE set: taken on the next cycle
      csr_mstatus_i = 32'h88;
      @(negedge clk); irq_i = 1'b0;
      chk_wr("unmask_mepc", 12'h341, 32'h500);
      @(negedge clk);
      chk_wr("unmask_mstatus", 12'h300, 32'h80);
      @(negedge clk);
      chk_wr("unmask_mcause", 12'h342, 32'h8000000B);
      @(negedge clk);
      chk_redir("unmask_redir", 32'h200);
      @(negedge clk);
      chk_idle("unmask_done");

      // mret: mstatus 0x80 -> 0x88, redirect to mepc on cycle 2
      csr_mstatus_i = 32'h80; csr_mepc_i = 32'h104; mret_i = 1'b1;
      @(negedge clk); mret_i = 1'b0;
      chk_wr("mret_mstatus", 12'h300, 32'h88);
      @(negedge clk);
      chk_redir("mret_redir", 32'h104);
      @(negedge clk);
      chk_idle("mret_done");

      // ebreak with EX CSR write stalling W_MSTATUS for 2 cycles
      csr_mstatus_i = 32'h8; inst_addr_i = 32'h120; ebreak_i = 1'b1;
      @(negedge clk); ebreak_i = 1'b0;
      chk_wr("stall_mepc", 12'h341, 32'h120);
      @(negedge clk); csr_ex_we_i = 1'b1;
      #1;
      chk("stall1_we", {31'd0, csr_intc_we_o}, 32'd0);
      chk("stall1_hold", {31'd0, hold_flag_o}, 32'd1);
      @(negedge clk);
      chk("stall2_we", {31'd0, csr_intc_we_o}, 32'd0);
      chk("stall2_ia", {31'd0, int_assert_o}, 32'd0);
      @(negedge clk); csr_ex_we_i = 1'b0;
      #1;
      chk_wr("stall_mstatus", 12'h300, 32'h80);
      @(negedge clk);
      chk_wr("stall_mcause", 12'h342, 32'h3);
      @(negedge clk);
      chk_redir("stall_redir", 32'h200);
      @(negedge clk);
      chk_idle("stall_done");

      // ecall and irq together: ecall wins; reset pulsed in W_MCAUSE
      inst_addr_i = 32'h100; ecall_i = 1'b1; irq_i = 1'b1;
      @(negedge clk); ecall_i = 1'b0; irq_i = 1'b0;
      chk_wr("prio_mepc", 12'h341, 32'h100);
      @(negedge clk);
      @(negedge clk);
      chk_wr("prio_mcause", 12'h342, 32'hB);
      #1 rst_n = 1'b0;
      #1;
      chk_idle("rst_mid");
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      chk_idle("rst_after");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
